// File: rtl/uart_cmd_decoder_pkg.sv
// Shared constants and TX handshake state encoding for the UART command decoder.
// Command bytes are matched case-insensitively by forcing the ASCII lower-case bit.
package uart_cmd_decoder_pkg;

   localparam logic [7:0] CMD_RUN_DEF   = 8'h52;
   localparam logic [7:0] CMD_CLR_DEF   = 8'h43;
   localparam logic [7:0] CMD_STAT_DEF  = 8'h53;

   localparam logic [7:0] REPLY_ONE     = 8'h31;
   localparam logic [7:0] REPLY_ZERO    = 8'h30;
   localparam logic [7:0] REPLY_UNKNOWN = 8'h3F;
   localparam logic [7:0] CHAR_CR       = 8'h0D;
   localparam logic [7:0] CHAR_LF       = 8'h0A;
   localparam logic [7:0] CASE_BIT      = 8'h20;

   typedef enum logic [1:0] {
      TX_IDLE    = 2'd0,
      TX_START   = 2'd1,
      TX_WAIT_HI = 2'd2,
      TX_WAIT_LO = 2'd3
   } tx_state_t;

   function automatic logic cmd_match(input logic [7:0] rx_byte, input logic [7:0] cmd);
      return (rx_byte | CASE_BIT) == (cmd | CASE_BIT);
   endfunction

endpackage

// File: rtl/cmd_reply_fifo.sv
// Synchronous reply FIFO, 8 bits wide. Pointers carry one extra wrap bit to tell full from empty.
// A push while full is accepted when a pop happens in the same cycle.
module cmd_reply_fifo #(
   parameter int DEPTH = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       push,
   input  logic [7:0] push_data,
   input  logic       pop,
   output logic [7:0] pop_data,
   output logic       full,
   output logic       empty
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

   logic [7:0]  mem [DEPTH];
   logic [AW:0] wr_ptr;
   logic [AW:0] rd_ptr;
   logic        push_ok;
   logic        pop_ok;

   assign empty    = (wr_ptr == rd_ptr);
   assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign pop_ok   = pop && !empty;
   assign push_ok  = push && (!full || pop_ok);
   assign pop_data = mem[rd_ptr[AW-1:0]];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (push_ok) wr_ptr <= wr_ptr + PTR_ONE;
         if (pop_ok)  rd_ptr <= rd_ptr + PTR_ONE;
      end
   end

   // Storage is not reset; the pointers alone define which entries are valid.
   always_ff @(posedge clk) begin
      if (push_ok) mem[wr_ptr[AW-1:0]] <= push_data;
   end

endmodule

// File: rtl/uart_cmd_decoder.sv
// Decodes UART command bytes into stopwatch control pulses and queues a one-byte reply per
// command, handing replies to the UART transmitter over a start/busy handshake.
module uart_cmd_decoder
   import uart_cmd_decoder_pkg::*;
#(
   parameter bit         ACK_EN     = 1'b1,
   parameter int         FIFO_DEPTH = 4,
   parameter logic [7:0] CMD_RUN    = CMD_RUN_DEF,
   parameter logic [7:0] CMD_CLR    = CMD_CLR_DEF,
   parameter logic [7:0] CMD_STAT   = CMD_STAT_DEF
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] i_rx_data,
   input  logic       i_rx_done,
   input  logic       i_run_state,
   output logic       o_runstop,
   output logic       o_clear,
   output logic       o_err,
   output logic       o_overrun,
   output logic [7:0] o_tx_data,
   output logic       o_tx_start,
   input  logic       i_tx_busy
);

   tx_state_t  state_q;
   tx_state_t  state_d;
   logic       is_run;
   logic       is_clr;
   logic       is_err;
   logic       reply_valid;
   logic [7:0] reply_byte;
   logic       push;
   logic       pop;
   logic       fifo_full;
   logic       fifo_empty;
   logic [7:0] fifo_rd_data;
   logic       tx_start_c;

   // CR/LF are screened on the raw byte before any case folding.
   always_comb begin
      is_run      = 1'b0;
      is_clr      = 1'b0;
      is_err      = 1'b0;
      reply_valid = 1'b0;
      reply_byte  = 8'h00;
      if (i_rx_done && i_rx_data != CHAR_CR && i_rx_data != CHAR_LF) begin
         reply_valid = 1'b1;
         if (cmd_match(i_rx_data, CMD_RUN)) begin
            is_run     = 1'b1;
            reply_byte = CMD_RUN;
         end else if (cmd_match(i_rx_data, CMD_CLR)) begin
            is_clr     = 1'b1;
            reply_byte = CMD_CLR;
         end else if (cmd_match(i_rx_data, CMD_STAT)) begin
            reply_byte = i_run_state ? REPLY_ONE : REPLY_ZERO;
         end else begin
            is_err     = 1'b1;
            reply_byte = REPLY_UNKNOWN;
         end
      end
   end

   assign push = ACK_EN && reply_valid;
   assign pop  = (state_q == TX_IDLE) && !fifo_empty && !i_tx_busy;

   cmd_reply_fifo #(
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (push),
      .push_data (reply_byte),
      .pop       (pop),
      .pop_data  (fifo_rd_data),
      .full      (fifo_full),
      .empty     (fifo_empty)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         o_runstop <= 1'b0;
         o_clear   <= 1'b0;
         o_err     <= 1'b0;
         o_overrun <= 1'b0;
         o_tx_data <= 8'h00;
         state_q   <= TX_IDLE;
      end else begin
         o_runstop <= is_run;
         o_clear   <= is_clr;
         o_err     <= is_err;
         o_overrun <= push && fifo_full && !pop;
         if (pop) o_tx_data <= fifo_rd_data;
         state_q   <= state_d;
      end
   end

   // Waiting for busy to rise and then fall guarantees one start per byte.
   always_comb begin
      state_d    = state_q;
      tx_start_c = 1'b0;
      case (state_q)
         TX_IDLE:    if (pop) state_d = TX_START;
         TX_START: begin
            tx_start_c = 1'b1;
            state_d    = TX_WAIT_HI;
         end
         TX_WAIT_HI: if (i_tx_busy) state_d = TX_WAIT_LO;
         TX_WAIT_LO: if (!i_tx_busy) state_d = TX_IDLE;
         default:    state_d = TX_IDLE;
      endcase
   end

   assign o_tx_start = tx_start_c;

endmodule

// File: tb/tb_uart_cmd_decoder.sv
// Self-checking bench for uart_cmd_decoder: directed scenarios plus randomized command bursts
// compared against a queue-based reply model and a simple transmitter model.
module tb_uart_cmd_decoder;

   logic       clk;
   logic       rst;
   logic [7:0] i_rx_data;
   logic       i_rx_done;
   logic       i_run_state;
   logic       o_runstop;
   logic       o_clear;
   logic       o_err;
   logic       o_overrun;
   logic [7:0] o_tx_data;
   logic       o_tx_start;
   logic       i_tx_busy;

   logic       busy_hold;
   logic       busy_tx;
   logic       long_busy;
   int         busy_cnt;

   int vectors;
   int miscompares;

   logic [7:0] exp_q [$];
   logic [3:0] exp_pulse;
   logic [7:0] mon_b;
   logic [7:0] mon_reply;
   logic       mon_has_reply;

   int runstop_cnt;
   int clear_cnt;
   int err_cnt;
   int overrun_cnt;
   int start_cnt;

   localparam int DEPTH = 4;

   uart_cmd_decoder dut (
      .clk         (clk),
      .rst         (rst),
      .i_rx_data   (i_rx_data),
      .i_rx_done   (i_rx_done),
      .i_run_state (i_run_state),
      .o_runstop   (o_runstop),
      .o_clear     (o_clear),
      .o_err       (o_err),
      .o_overrun   (o_overrun),
      .o_tx_data   (o_tx_data),
      .o_tx_start  (o_tx_start),
      .i_tx_busy   (i_tx_busy)
   );

   assign i_tx_busy = busy_hold | busy_tx;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [15:0] observed, input logic [15:0] expected);
      vectors++;
      if (observed !== expected) begin
         miscompares++;
         $display("[TB] FAIL %s: got %h, expected %h at %0t", tag, observed, expected, $time);
      end
   endtask

   // Monitor at the falling edge: compare last cycle's prediction, model the transmitter,
   // then predict the next cycle from the inputs currently applied.
   always @(negedge clk) begin
      if (rst) begin
         checkOutput("reset_outputs",
                     {3'b0, o_runstop, o_clear, o_err, o_overrun, o_tx_start, o_tx_data}, 16'h0000);
         exp_pulse = 4'b0000;
         exp_q.delete();
         busy_tx  = 1'b0;
         busy_cnt = 0;
      end else begin
         checkOutput("pulses", {12'b0, o_runstop, o_clear, o_err, o_overrun}, {12'b0, exp_pulse});
         if (o_runstop) runstop_cnt++;
         if (o_clear)   clear_cnt++;
         if (o_err)     err_cnt++;
         if (o_overrun) overrun_cnt++;
         if (o_tx_start) begin
            start_cnt++;
            if (exp_q.size() == 0) checkOutput("unexpected_start", 16'd1, 16'd0);
            else checkOutput("tx_data", {8'h00, o_tx_data}, {8'h00, exp_q.pop_front()});
            busy_tx  = 1'b1;
            busy_cnt = long_busy ? 20 : int'($urandom_range(2, 5));
         end else if (busy_cnt > 0) begin
            busy_cnt--;
            if (busy_cnt == 0) busy_tx = 1'b0;
         end

         exp_pulse     = 4'b0000;
         mon_has_reply = 1'b0;
         mon_reply     = 8'h00;
         if (i_rx_done) begin
            mon_b = i_rx_data;
            if (mon_b == 8'h0D || mon_b == 8'h0A) begin
               mon_has_reply = 1'b0;
            end else if ((mon_b | 8'h20) == 8'h72) begin
               exp_pulse[3] = 1'b1;
               mon_reply = 8'h52;
               mon_has_reply = 1'b1;
            end else if ((mon_b | 8'h20) == 8'h63) begin
               exp_pulse[2] = 1'b1;
               mon_reply = 8'h43;
               mon_has_reply = 1'b1;
            end else if ((mon_b | 8'h20) == 8'h73) begin
               mon_reply = i_run_state ? 8'h31 : 8'h30;
               mon_has_reply = 1'b1;
            end else begin
               exp_pulse[1] = 1'b1;
               mon_reply = 8'h3F;
               mon_has_reply = 1'b1;
            end
            if (mon_has_reply) begin
               if (exp_q.size() >= DEPTH) exp_pulse[0] = 1'b1;
               else exp_q.push_back(mon_reply);
            end
         end
      end
   end

   task automatic applyStimulus(input logic [7:0] b, input logic run);
      @(posedge clk);
      #2;
      i_rx_data   = b;
      i_rx_done   = 1'b1;
      i_run_state = run;
   endtask

   task automatic idleInputs(input int cycles);
      for (int i = 0; i < cycles; i++) begin
         @(posedge clk);
         #2;
         i_rx_done = 1'b0;
         i_rx_data = 8'h00;
      end
   endtask

   task automatic waitDrain();
      int budget;
      budget = 0;
      while ((exp_q.size() != 0 || busy_tx) && budget < 300) begin
         @(posedge clk);
         budget++;
      end
      if (budget >= 300) checkOutput("drain_timeout", 16'd1, 16'd0);
      idleInputs(3);
   endtask

   initial begin
      int s_run, s_clr, s_err, s_ovr, s_start, budget, burst, pick;
      logic [7:0] table_b [8];
      logic [7:0] rb;
      table_b[0] = 8'h52; table_b[1] = 8'h72; table_b[2] = 8'h43; table_b[3] = 8'h63;
      table_b[4] = 8'h53; table_b[5] = 8'h73; table_b[6] = 8'h0D; table_b[7] = 8'h0A;

      vectors = 0; miscompares = 0;
      runstop_cnt = 0; clear_cnt = 0; err_cnt = 0; overrun_cnt = 0; start_cnt = 0;
      busy_hold = 1'b0; long_busy = 1'b0;
      i_rx_data = 8'h00; i_rx_done = 1'b0; i_run_state = 1'b0;
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #2 rst = 1'b0;
      idleInputs(2);

      $display("[TB] R then r");
      s_run = runstop_cnt; s_start = start_cnt;
      applyStimulus(8'h52, 1'b0);
      applyStimulus(8'h72, 1'b0);
      idleInputs(1);
      waitDrain();
      checkOutput("runstop_count_Rr", 16'(runstop_cnt - s_run), 16'd2);
      checkOutput("start_count_Rr", 16'(start_cnt - s_start), 16'd2);

      $display("[TB] c clear");
      s_clr = clear_cnt; s_start = start_cnt;
      applyStimulus(8'h63, 1'b1);
      idleInputs(1);
      waitDrain();
      checkOutput("clear_count", 16'(clear_cnt - s_clr), 16'd1);
      checkOutput("start_count_c", 16'(start_cnt - s_start), 16'd1);

      $display("[TB] status queries");
      s_start = start_cnt;
      applyStimulus(8'h53, 1'b1);
      applyStimulus(8'h53, 1'b0);
      idleInputs(1);
      waitDrain();
      checkOutput("start_count_S", 16'(start_cnt - s_start), 16'd2);

      $display("[TB] unknown byte, CR, LF");
      s_err = err_cnt; s_start = start_cnt;
      applyStimulus(8'h78, 1'b0);
      applyStimulus(8'h0D, 1'b0);
      applyStimulus(8'h0A, 1'b0);
      idleInputs(1);
      waitDrain();
      checkOutput("err_count", 16'(err_cnt - s_err), 16'd1);
      checkOutput("start_count_x", 16'(start_cnt - s_start), 16'd1);

      $display("[TB] overrun with transmitter held busy");
      @(posedge clk);
      #2 busy_hold = 1'b1;
      idleInputs(2);
      s_run = runstop_cnt; s_ovr = overrun_cnt; s_start = start_cnt;
      for (int i = 0; i < 6; i++) applyStimulus(8'h52, 1'b0);
      idleInputs(4);
      checkOutput("runstop_count_6R", 16'(runstop_cnt - s_run), 16'd6);
      checkOutput("overrun_count", 16'(overrun_cnt - s_ovr), 16'd2);
      checkOutput("start_while_busy", 16'(start_cnt - s_start), 16'd0);
      @(posedge clk);
      #2 busy_hold = 1'b0;
      waitDrain();
      checkOutput("start_after_release", 16'(start_cnt - s_start), 16'd4);

      $display("[TB] reset during transfer");
      long_busy = 1'b1;
      s_start = start_cnt;
      applyStimulus(8'h52, 1'b0);
      applyStimulus(8'h52, 1'b0);
      applyStimulus(8'h52, 1'b0);
      idleInputs(1);
      budget = 0;
      while (start_cnt == s_start && budget < 50) begin
         @(posedge clk);
         budget++;
      end
      if (budget >= 50) checkOutput("first_start_timeout", 16'd1, 16'd0);
      idleInputs(4);
      @(posedge clk);
      #2 rst = 1'b1;
      repeat (2) @(posedge clk);
      #2 rst = 1'b0;
      long_busy = 1'b0;
      idleInputs(2);
      s_start = start_cnt;
      applyStimulus(8'h43, 1'b0);
      idleInputs(1);
      waitDrain();
      idleInputs(10);
      checkOutput("start_after_reset", 16'(start_cnt - s_start), 16'd1);

      $display("[TB] randomized bursts");
      s_ovr = overrun_cnt;
      for (int n = 0; n < 60; n++) begin
         burst = int'($urandom_range(1, DEPTH));
         for (int k = 0; k < burst; k++) begin
            pick = int'($urandom_range(0, 11));
            if (pick < 8) rb = table_b[pick];
            else rb = 8'($urandom);
            applyStimulus(rb, 1'($urandom));
            if ($urandom_range(0, 2) == 0) idleInputs(1);
         end
         idleInputs(1);
         waitDrain();
      end
      checkOutput("random_overrun_count", 16'(overrun_cnt - s_ovr), 16'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #2000000;
      $display("[TB] FAIL global_timeout: simulation did not complete");
      $fatal(1, "[TB] timeout");
   end

endmodule
